aes_lite_regs: RTL
==================

Name: aes_lite_regs

Overview:
- Register bank and control FSM that sits directly downstream of the AXI-Lite write path in the AES peripheral.
- Consumes the decoded single-cycle write strobe (address, data, write) and serves combinational read data back to the AXI-Lite slave.
- Drives key, data-in, start and mode into the AES core, captures its result, and raises an interrupt.

Parameters:
C_ADDR_WIDTH, 10, byte address width of the register strobe/read address
C_DATA_WIDTH, 32, register width; only 32 supported
C_TIMEOUT, 1024, max cycles in RUN before the operation is aborted (>=2)
C_VERSION, 32'h0102_0304, value returned by the VERSION register

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
reg_data_write  in  1  single-cycle write strobe
reg_data_addr  in  C_ADDR_WIDTH  write byte address
reg_data  in  32  write data
rd_addr  in  C_ADDR_WIDTH  read byte address (held by the slave)
rd_data  out  32  read data, combinational from rd_addr
aes_key  out  128  key; KEY0 maps to [31:0]
aes_din  out  128  input block; DIN0 maps to [31:0]
aes_decrypt  out  1  mode: 1 = decrypt
aes_start  out  1  one-cycle start pulse
aes_done  in  1  one-cycle completion pulse from core
aes_dout  in  128  core result, valid with aes_done
irq  out  1  registered level interrupt

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- At reset: every register, aes_start, irq and the FSM are cleared to 0, FSM goes to IDLE. rd_data still reflects VERSION at 0x08.
- Decode uses addr[5:2]. If addr[9:6] != 0, writes are ignored and reads return 0. addr[1:0] is ignored. Only full-word writes are supported.
- Register map:
  - 0x00 CTRL RW:
    - bit0 START: write-1 triggers a start; always reads 0.
    - bit1 DECRYPT.
    - bit2 IRQ_EN.
  - 0x04 STATUS:
    - bit0 BUSY: read-only.
    - bit1 DONE: write-1-to-clear.
    - bit2 ERR: write-1-to-clear.
    - bit3 TMO: write-1-to-clear.
  - 0x08 VERSION RO: returns C_VERSION.
  - 0x0C SCRATCH RW.
  - 0x10-0x1C KEY0-3 RW.
  - 0x20-0x2C DIN0-3 RW.
  - 0x30-0x3C DOUT0-3 RO: captured from aes_dout.
  - Unmapped offsets read 0.
- FSM states are IDLE and RUN; BUSY=1 exactly in RUN.
- IDLE:
  - A CTRL write with bit0=1 asserts aes_start in the next cycle for exactly one cycle and enters RUN.
  - DECRYPT takes the written bit1 in the same write, so it is valid with aes_start.
  - The timeout counter clears.
- RUN:
  - Counter increments each cycle.
  - aes_done: latch aes_dout into DOUT0-3, set DONE, go to IDLE.
  - Counter reaches C_TIMEOUT-1 without aes_done: set TMO, leave DOUT unchanged, go to IDLE.
  - aes_done on the same cycle as the timeout: done wins and TMO is not set.
- Writes while in RUN:
  - A write to KEY, DIN or CTRL.DECRYPT is dropped and sets ERR.
  - CTRL START=1 in RUN: no pulse, ERR set.
  - CTRL IRQ_EN is still writable.
- aes_done in IDLE is ignored: no capture, no flag.
- Flag set/clear collisions: if a W1C write and a set event hit the same flag in the same cycle, the set wins (flag remains 1).
- irq is registered: irq <= IRQ_EN & (DONE | ERR | TMO), one cycle after the flags. Clearing IRQ_EN drops irq the next cycle.
- Reset asserted mid-RUN returns to IDLE with all registers cleared. A later aes_done is ignored.
- A write from the bus is visible on rd_data in the cycle after the strobe.

Decomposition:
- Shared package `aes_lite_pkg`:
  - Register offset localparams: CTRL, STATUS, VERSION, SCRATCH, KEY0, DIN0, DOUT0.
  - CTRL/STATUS bit-index localparams.
  - FSM state encodings S_IDLE and S_RUN.
- One natural sub-module, `aes_lite_seq`: the IDLE/RUN FSM plus the timeout counter, producing start, busy, capture and tmo. The register bank stays in the top level.

Test Plan:
- Reset, then read 0x08, 0x04, 0x10 -> 0x0102_0304, 0, 0; aes_start=0, irq=0.
- Write KEY0-3 = 0x11111111..0x44444444, DIN0 = 0xA5A5A5A5, then CTRL=0x1 -> aes_start high exactly 1 cycle after the strobe; aes_key[31:0]=0x11111111, aes_key[127:96]=0x44444444; STATUS=0x1.
- In RUN, pulse aes_done with aes_dout=128'h0123..CDEF -> DOUT0 reads the low word; STATUS=0x2. With IRQ_EN previously set, irq rises 1 cycle after the DONE flag. Writing STATUS=0x2 clears it and irq drops.
- In RUN, write CTRL=0x1 and KEY0=0xFFFFFFFF -> no second aes_start, KEY0 unchanged, STATUS bit2=1.
- C_TIMEOUT=8, no aes_done -> BUSY falls after 8 RUN cycles, STATUS=0x8, DOUT unchanged. A variant with aes_done on the 8th cycle gives STATUS=0x2.
- In the same cycle as aes_done, write STATUS=0x2 -> DONE remains 1. Assert reset mid-RUN -> all reads 0 except VERSION; a subsequent aes_done is ignored.

Source files
------------

// File: rtl/aes_lite_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_lite_pkg
// Brief    : Register map, CTRL/STATUS bit indices and FSM states for aes_lite.
// Revision : 1.0 - initial release
// ============================================================================
package aes_lite_pkg;

  localparam logic [5:0] c_off_ctrl    = 6'h00;
  localparam logic [5:0] c_off_status  = 6'h04;
  localparam logic [5:0] c_off_version = 6'h08;
  localparam logic [5:0] c_off_scratch = 6'h0C;
  localparam logic [5:0] c_off_key0    = 6'h10;
  localparam logic [5:0] c_off_din0    = 6'h20;
  localparam logic [5:0] c_off_dout0   = 6'h30;

  localparam int c_ctrl_start   = 0;
  localparam int c_ctrl_decrypt = 1;
  localparam int c_ctrl_irq_en  = 2;

  localparam int c_st_busy = 0;
  localparam int c_st_done = 1;
  localparam int c_st_err  = 2;
  localparam int c_st_tmo  = 3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/aes_lite_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_lite_regs_if
// Brief    : Decoded register write strobe and combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_lite_regs_if #(
  parameter int unsigned C_ADDR_WIDTH = 10,
  parameter int unsigned C_DATA_WIDTH = 32
);
  logic                    reg_data_write;
  logic [C_ADDR_WIDTH-1:0] reg_data_addr;
  logic [C_DATA_WIDTH-1:0] reg_data;
  logic [C_ADDR_WIDTH-1:0] rd_addr;
  logic [C_DATA_WIDTH-1:0] rd_data;

  modport master (
    output reg_data_write, reg_data_addr, reg_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  reg_data_write, reg_data_addr, reg_data, rd_addr,
    output rd_data
  );
endinterface
`default_nettype wire

// File: rtl/aes_lite_regs_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_lite_seq
// Brief    : IDLE/RUN sequencer with start pulse and operation timeout.
// Revision : 1.0 - initial release
// ============================================================================
module aes_lite_seq
  import aes_lite_pkg::*;
#(
  parameter int unsigned C_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start_req,
  input  logic aes_done,
  output logic start,
  output logic busy,
  output logic capture,
  output logic tmo
);

  localparam int unsigned            c_cnt_w    = $clog2(C_TIMEOUT);
  localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(C_TIMEOUT - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_start;
  logic                 w_start_nxt;
  logic [c_cnt_w-1:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_start_nxt;
      r_cnt   <= (r_state == S_RUN) ? r_cnt + c_cnt_w'(1) : '0;
    end
  end

  // Completion is checked before timeout so a done on the last cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    capture     = 1'b0;
    tmo         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_req) begin
          w_state_nxt = S_RUN;
          w_start_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (aes_done) begin
          capture     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_cnt_last) begin
          tmo         = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign start = r_start;
  assign busy  = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: rtl/aes_lite_regs.sv
`default_nettype none
// ============================================================================
// Module   : aes_lite_regs
// Brief    : AES peripheral register bank, status flags and interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module aes_lite_regs
  import aes_lite_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 10,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT    = 1024,
  parameter logic [31:0] C_VERSION    = 32'h0102_0304
) (
  input  logic                      clk,
  input  logic                      reset,
  aes_lite_regs_if.slave            bus,
  output logic [4*C_DATA_WIDTH-1:0] aes_key,
  output logic [4*C_DATA_WIDTH-1:0] aes_din,
  output logic                      aes_decrypt,
  output logic                      aes_start,
  input  logic                      aes_done,
  input  logic [4*C_DATA_WIDTH-1:0] aes_dout,
  output logic                      irq
);

  localparam logic [3:0] c_w_ctrl    = c_off_ctrl[5:2];
  localparam logic [3:0] c_w_status  = c_off_status[5:2];
  localparam logic [3:0] c_w_version = c_off_version[5:2];
  localparam logic [3:0] c_w_scratch = c_off_scratch[5:2];
  localparam logic [3:0] c_w_key0    = c_off_key0[5:2];
  localparam logic [3:0] c_w_din0    = c_off_din0[5:2];
  localparam logic [3:0] c_w_dout0   = c_off_dout0[5:2];

  logic [C_DATA_WIDTH-1:0] r_key  [4];
  logic [C_DATA_WIDTH-1:0] r_din  [4];
  logic [C_DATA_WIDTH-1:0] r_dout [4];
  logic [C_DATA_WIDTH-1:0] r_scratch;
  logic                    r_decrypt;
  logic                    r_irq_en;
  logic                    r_done;
  logic                    r_err;
  logic                    r_tmo;
  logic                    r_irq;

  logic                    w_wr;
  logic [3:0]              w_widx;
  logic [3:0]              w_ridx;
  logic                    w_ctrl_wr;
  logic                    w_st_wr;
  logic                    w_key_wr;
  logic                    w_din_wr;
  logic                    w_ctrl_bad;
  logic                    w_err_evt;
  logic                    w_start_req;
  logic                    w_busy;
  logic                    w_capture;
  logic                    w_tmo;
  logic [C_DATA_WIDTH-1:0] w_rd_data;
  logic                    w_unused_addr_lsbs;

  assign w_wr      = bus.reg_data_write && (bus.reg_data_addr[C_ADDR_WIDTH-1:6] == '0);
  assign w_widx    = bus.reg_data_addr[5:2];
  assign w_ridx    = bus.rd_addr[5:2];
  assign w_ctrl_wr = w_wr && (w_widx == c_w_ctrl);
  assign w_st_wr   = w_wr && (w_widx == c_w_status);
  assign w_key_wr  = w_wr && (w_widx[3:2] == c_w_key0[3:2]);
  assign w_din_wr  = w_wr && (w_widx[3:2] == c_w_din0[3:2]);

  // A CTRL write in RUN is an error only if it tries to start or change mode.
  assign w_ctrl_bad  = bus.reg_data[c_ctrl_start] |
                       (bus.reg_data[c_ctrl_decrypt] != r_decrypt);
  assign w_err_evt   = w_busy & ((w_ctrl_wr & w_ctrl_bad) | w_key_wr | w_din_wr);
  assign w_start_req = w_ctrl_wr & bus.reg_data[c_ctrl_start];

  assign w_unused_addr_lsbs = ^{bus.reg_data_addr[1:0], bus.rd_addr[1:0]};

  aes_lite_seq #(
    .C_TIMEOUT (C_TIMEOUT)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start_req (w_start_req),
    .aes_done  (aes_done),
    .start     (aes_start),
    .busy      (w_busy),
    .capture   (w_capture),
    .tmo       (w_tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_key[i]  <= '0;
        r_din[i]  <= '0;
        r_dout[i] <= '0;
      end
      r_scratch <= '0;
      r_decrypt <= 1'b0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_tmo     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_irq_en <= bus.reg_data[c_ctrl_irq_en];
        if (!w_busy) r_decrypt <= bus.reg_data[c_ctrl_decrypt];
      end
      if (w_wr && (w_widx == c_w_scratch)) r_scratch <= bus.reg_data;
      if (w_key_wr && !w_busy) r_key[w_widx[1:0]] <= bus.reg_data;
      if (w_din_wr && !w_busy) r_din[w_widx[1:0]] <= bus.reg_data;
      if (w_capture) begin
        for (int i = 0; i < 4; i++) r_dout[i] <= aes_dout[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
      // Set events take priority over a same-cycle write-1-to-clear.
      r_done <= w_capture | (r_done & ~(w_st_wr & bus.reg_data[c_st_done]));
      r_err  <= w_err_evt | (r_err  & ~(w_st_wr & bus.reg_data[c_st_err]));
      r_tmo  <= w_tmo     | (r_tmo  & ~(w_st_wr & bus.reg_data[c_st_tmo]));
      r_irq  <= r_irq_en & (r_done | r_err | r_tmo);
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (bus.rd_addr[C_ADDR_WIDTH-1:6] == '0) begin
      case (w_ridx)
        c_w_ctrl: begin
          w_rd_data[c_ctrl_decrypt] = r_decrypt;
          w_rd_data[c_ctrl_irq_en]  = r_irq_en;
        end
        c_w_status: begin
          w_rd_data[c_st_busy] = w_busy;
          w_rd_data[c_st_done] = r_done;
          w_rd_data[c_st_err]  = r_err;
          w_rd_data[c_st_tmo]  = r_tmo;
        end
        c_w_version: w_rd_data = C_VERSION;
        c_w_scratch: w_rd_data = r_scratch;
        default: begin
          if (w_ridx[3:2] == c_w_key0[3:2])       w_rd_data = r_key[w_ridx[1:0]];
          else if (w_ridx[3:2] == c_w_din0[3:2])  w_rd_data = r_din[w_ridx[1:0]];
          else if (w_ridx[3:2] == c_w_dout0[3:2]) w_rd_data = r_dout[w_ridx[1:0]];
        end
      endcase
    end
  end

  assign bus.rd_data = w_rd_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign aes_key[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = r_key[gi];
    assign aes_din[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = r_din[gi];
  end

  assign aes_decrypt = r_decrypt;
  assign irq         = r_irq;

endmodule
`default_nettype wire
